// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives the IF/ID and ID/EX register enables.
// Detects load-use hazards, inserts bubbles, flushes on EX redirects and
// freezes the front end while data memory is busy.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 idex_mem_read,
    input  logic [4:0]           idex_dest_reg,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_redirect,
    input  logic                 mem_wait,
    output logic                 pc_write_en,
    output logic                 ifid_write_en,
    output logic                 ifid_flush,
    output logic                 idex_write_en,
    output logic                 idex_bubble,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    // Counter preload: the RUN hazard cycle is the first bubble.
    localparam logic [1:0] STALL_PRELOAD = 2'(LOAD_USE_STALL - 1);

    logic [1:0] r_state;
    logic [1:0] r_stall_cnt;
    logic [1:0] w_next_state;
    logic [1:0] w_next_cnt;
    logic       w_hazard;
    logic       w_pc_we;
    logic       w_ifid_we;
    logic       w_ifid_flush;
    logic       w_idex_we;
    logic       w_idex_bubble;

    // Load-use hazard between the load in EX and the operands in decode.
    always_comb begin
        w_hazard = idex_mem_read && (idex_dest_reg != 5'd0) &&
                   ((idex_dest_reg == id_rs) ||
                    (id_uses_rt && (idex_dest_reg == id_rt)));
    end

    // Enables and next state; priority is reset > mem_wait > redirect > hazard.
    always_comb begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_we     = 1'b0;
        w_idex_bubble = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_stall_cnt;
        if (reset) begin
            w_idex_bubble = 1'b1;
        end else if (mem_wait) begin
            // Whole front end frozen; state and counter hold.
            w_pc_we = 1'b0;
        end else begin
            case (r_state)
                STALL: begin
                    // EX holds a bubble here, so a redirect cannot be real.
                    w_idex_we     = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_next_cnt    = r_stall_cnt - 2'd1;
                    if (r_stall_cnt == 2'd1) begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    if (ex_redirect) begin
                        w_pc_we       = 1'b1;
                        w_ifid_we     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_we     = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_next_state  = FLUSH;
                    end else if ((r_state == RUN) && w_hazard) begin
                        // IF/ID holds a NOP while in FLUSH, so no hazard there.
                        w_idex_we     = 1'b1;
                        w_idex_bubble = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            w_next_cnt   = STALL_PRELOAD;
                            w_next_state = STALL;
                        end
                    end else begin
                        w_pc_we      = 1'b1;
                        w_ifid_we    = 1'b1;
                        w_idex_we    = 1'b1;
                        w_next_state = RUN;
                    end
                end
            endcase
        end
    end

    assign pc_write_en   = w_pc_we;
    assign ifid_write_en = w_ifid_we;
    assign ifid_flush    = w_ifid_flush;
    assign idex_write_en = w_idex_we;
    assign idex_bubble   = w_idex_bubble;

    // FSM state and remaining-bubble counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_stall_cnt <= w_next_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic                 w_redirect_acc;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_redirect_count;

    assign w_redirect_acc = !mem_wait && ex_redirect && (r_state != STALL);

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if (!w_pc_we && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_redirect_acc && !(&r_redirect_count)) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`else
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: one instance with
// LOAD_USE_STALL=1 and one with LOAD_USE_STALL=3 share the same stimulus.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble}
    localparam logic [4:0] RUNO = 5'b11010;
    localparam logic [4:0] BUB  = 5'b00011;
    localparam logic [4:0] FLU  = 5'b11111;
    localparam logic [4:0] FRZ  = 5'b00000;
    localparam logic [4:0] RSTO = 5'b00001;

    logic        clock;
    logic        reset;
    logic        idex_mem_read;
    logic [4:0]  idex_dest_reg;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_redirect;
    logic        mem_wait;
    logic        pc1, ifid1, fl1, idex1, bub1;
    logic        pc3, ifid3, fl3, idex3, bub3;
    logic [15:0] sc1, rc1, sc3, rc3;
    logic [4:0]  w1, w3;
    int          n_vec;
    int          n_err;

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_WIDTH(16)) dut1 (
        .clock(clock), .reset(reset), .idex_mem_read(idex_mem_read),
        .idex_dest_reg(idex_dest_reg), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
        .pc_write_en(pc1), .ifid_write_en(ifid1), .ifid_flush(fl1),
        .idex_write_en(idex1), .idex_bubble(bub1),
        .stall_cycles(sc1), .redirect_count(rc1)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_WIDTH(16)) dut3 (
        .clock(clock), .reset(reset), .idex_mem_read(idex_mem_read),
        .idex_dest_reg(idex_dest_reg), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
        .pc_write_en(pc3), .ifid_write_en(ifid3), .ifid_flush(fl3),
        .idex_write_en(idex3), .idex_bubble(bub3),
        .stall_cycles(sc3), .redirect_count(rc3)
    );

    assign w1 = {pc1, ifid1, fl1, idex1, bub1};
    assign w3 = {pc3, ifid3, fl3, idex3, bub3};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic mr, input logic [4:0] dest, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic redir,
                         input logic mw);
        idex_mem_read = mr;
        idex_dest_reg = dest;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rt    = urt;
        ex_redirect   = redir;
        mem_wait      = mw;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (w1 !== RSTO) begin $display("FAIL reset_out1 got %b exp %b", w1, RSTO); n_err++; end
        n_vec++; if (w3 !== RSTO) begin $display("FAIL reset_out3 got %b exp %b", w3, RSTO); n_err++; end
        n_vec++; if ({sc1, rc1} !== 32'd0) begin $display("FAIL reset_cnt got %h exp 0", {sc1, rc1}); n_err++; end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_vec++; if (w1 !== RUNO) begin $display("FAIL post_reset got %b exp %b", w1, RUNO); n_err++; end
        tick();
    endtask

    task automatic test_load_use();
        pulse_reset();
        drive(1, 8, 8, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w1 !== BUB) begin $display("FAIL lu_rs_c1 got %b exp %b", w1, BUB); n_err++; end
        tick();
        drive(0, 0, 8, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w1 !== RUNO) begin $display("FAIL lu_rs_c2 got %b exp %b", w1, RUNO); n_err++; end
        tick();
    endtask

    task automatic test_lus3_rt();
        pulse_reset();
        drive(1, 9, 0, 9, 1, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL lus3_c1 got %b exp %b", w3, BUB); n_err++; end
        n_vec++; if (w1 !== BUB) begin $display("FAIL lus1_rt_c1 got %b exp %b", w1, BUB); n_err++; end
        tick();
        drive(0, 0, 0, 9, 1, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL lus3_c2 got %b exp %b", w3, BUB); n_err++; end
        n_vec++; if (w1 !== RUNO) begin $display("FAIL lus1_rt_c2 got %b exp %b", w1, RUNO); n_err++; end
        tick();
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL lus3_c3 got %b exp %b", w3, BUB); n_err++; end
        tick();
        @(negedge clock);
        n_vec++; if (w3 !== RUNO) begin $display("FAIL lus3_c4 got %b exp %b", w3, RUNO); n_err++; end
        tick();
        drive(1, 9, 0, 9, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== RUNO) begin $display("FAIL rt_unused3 got %b exp %b", w3, RUNO); n_err++; end
        n_vec++; if (w1 !== RUNO) begin $display("FAIL rt_unused1 got %b exp %b", w1, RUNO); n_err++; end
        tick();
    endtask

    task automatic test_zero_dest();
        pulse_reset();
        drive(1, 0, 0, 0, 1, 0, 0);
        @(negedge clock);
        n_vec++; if (w1 !== RUNO) begin $display("FAIL zero_dest1 got %b exp %b", w1, RUNO); n_err++; end
        n_vec++; if (w3 !== RUNO) begin $display("FAIL zero_dest3 got %b exp %b", w3, RUNO); n_err++; end
        tick();
    endtask

    task automatic test_redirect();
        pulse_reset();
        drive(1, 8, 8, 0, 0, 1, 0);
        @(negedge clock);
        n_vec++; if (w1 !== FLU) begin $display("FAIL redir_wins1 got %b exp %b", w1, FLU); n_err++; end
        n_vec++; if (w3 !== FLU) begin $display("FAIL redir_wins3 got %b exp %b", w3, FLU); n_err++; end
        tick();
        drive(1, 8, 8, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w1 !== RUNO) begin $display("FAIL flush_nohaz1 got %b exp %b", w1, RUNO); n_err++; end
        n_vec++; if (w3 !== RUNO) begin $display("FAIL flush_nohaz3 got %b exp %b", w3, RUNO); n_err++; end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        n_vec++; if (w1 !== FLU) begin $display("FAIL redir_b2b_a got %b exp %b", w1, FLU); n_err++; end
        tick();
        @(negedge clock);
        n_vec++; if (w1 !== FLU) begin $display("FAIL redir_b2b_b got %b exp %b", w1, FLU); n_err++; end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w1 !== RUNO) begin $display("FAIL redir_b2b_end got %b exp %b", w1, RUNO); n_err++; end
        tick();
        drive(1, 8, 8, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL stall_entry3 got %b exp %b", w3, BUB); n_err++; end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL stall_ign_redir got %b exp %b", w3, BUB); n_err++; end
        n_vec++; if (w1 !== FLU) begin $display("FAIL run_redir1 got %b exp %b", w1, FLU); n_err++; end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL stall_last3 got %b exp %b", w3, BUB); n_err++; end
        n_vec++; if (rc1 !== (PERF ? 16'd4 : 16'd0)) begin
            $display("FAIL redir_cnt1 got %0d exp %0d", rc1, (PERF ? 4 : 0)); n_err++; end
        n_vec++; if (rc3 !== (PERF ? 16'd3 : 16'd0)) begin
            $display("FAIL redir_cnt3 got %0d exp %0d", rc3, (PERF ? 3 : 0)); n_err++; end
        tick();
    endtask

    task automatic test_mem_wait_stall();
        pulse_reset();
        drive(1, 8, 8, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL mw_haz3 got %b exp %b", w3, BUB); n_err++; end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, (i == 1), 1);
            @(negedge clock);
            n_vec++; if (w3 !== FRZ) begin $display("FAIL mw_frz3_%0d got %b exp %b", i, w3, FRZ); n_err++; end
            n_vec++; if (w1 !== FRZ) begin $display("FAIL mw_frz1_%0d got %b exp %b", i, w1, FRZ); n_err++; end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL mw_resume_a got %b exp %b", w3, BUB); n_err++; end
        n_vec++; if (w1 !== RUNO) begin $display("FAIL mw_resume1 got %b exp %b", w1, RUNO); n_err++; end
        tick();
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL mw_resume_b got %b exp %b", w3, BUB); n_err++; end
        tick();
        @(negedge clock);
        n_vec++; if (w3 !== RUNO) begin $display("FAIL mw_done got %b exp %b", w3, RUNO); n_err++; end
        n_vec++; if (sc3 !== (PERF ? 16'd7 : 16'd0)) begin
            $display("FAIL stall_cnt3 got %0d exp %0d", sc3, (PERF ? 7 : 0)); n_err++; end
        n_vec++; if (sc1 !== (PERF ? 16'd5 : 16'd0)) begin
            $display("FAIL stall_cnt1 got %0d exp %0d", sc1, (PERF ? 5 : 0)); n_err++; end
        n_vec++; if (rc1 !== 16'd0) begin $display("FAIL mw_redir_cnt got %0d exp 0", rc1); n_err++; end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        pulse_reset();
        drive(1, 8, 8, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        n_vec++; if (w3 !== BUB) begin $display("FAIL mid_stall got %b exp %b", w3, BUB); n_err++; end
        tick();
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (w3 !== RSTO) begin $display("FAIL mid_rst_out got %b exp %b", w3, RSTO); n_err++; end
        n_vec++; if ({sc3, rc3} !== 32'd0) begin $display("FAIL mid_rst_cnt got %h exp 0", {sc3, rc3}); n_err++; end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_vec++; if (w3 !== RUNO) begin $display("FAIL mid_rst_run got %b exp %b", w3, RUNO); n_err++; end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_lus3_rt();
        test_zero_dest();
        test_redirect();
        test_mem_wait_stall();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
